// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the Genius push-button front-end.
// Build option BTN_ACTIVE_LOW_EN selects pulled-up (active-low) raw keys.
package button_conditioner_pkg;

    localparam int NUM_COLOR_KEYS = 4;
    localparam int COLOR_W        = 2;

`ifdef BTN_ACTIVE_LOW_EN
    localparam logic RAW_IDLE_LVL = 1'b1;
`else
    localparam logic RAW_IDLE_LVL = 1'b0;
`endif

    typedef enum logic [COLOR_W-1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_t;

    typedef enum logic [0:0] {
        BTN_IDLE = 1'b0,
        BTN_HELD = 1'b1
    } btn_state_t;

    // Only meaningful for a one-hot key vector.
    function automatic color_t encode_color(input logic [NUM_COLOR_KEYS-1:0] keys);
        color_t c;
        case (keys)
            4'b0001: c = RED;
            4'b0010: c = GREEN;
            4'b0100: c = BLUE;
            4'b1000: c = YELLOW;
            default: c = RED;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/button_conditioner_debouncer.sv
// One key: 2-FF synchroniser, polarity normalisation and a hold-time debounce counter.
// The debounced level is 1 while the key is pressed, in either input polarity.
module button_conditioner_debouncer
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
)(
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             pressed_s;
    logic             state_q;
    logic             state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign pressed_s = sync2_q ^ RAW_IDLE_LVL;

    // Synchroniser flops start at the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RAW_IDLE_LVL;
            sync2_q <= RAW_IDLE_LVL;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Counter tops out at DEBOUNCE_CYCLES-1, where it toggles the state and clears.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (pressed_s == state_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_d = ~state_q;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Genius key front-end: debounces 4 color keys + start, emits one strobe per press.
// Raw key polarity follows BTN_ACTIVE_LOW_EN (see package); outputs are active-high.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int COLOR_CODEFY_W  = 2
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [3:0]                btn_raw,
    input  logic                      start_raw,
    output logic [COLOR_CODEFY_W-1:0] player_button,
    output logic                      player_valid,
    output logic                      start_pulse,
    output logic                      multi_press
);

    logic [NUM_COLOR_KEYS:0]   raw_all_s;
    logic [NUM_COLOR_KEYS:0]   level_s;
    logic [NUM_COLOR_KEYS-1:0] keys_s;
    logic                      start_lvl_s;
    logic                      one_hot_s;
    logic                      multi_s;

    btn_state_t                state_q, state_d;
    logic                      blocked_q, blocked_d;
    logic [COLOR_CODEFY_W-1:0] button_q, button_d;
    logic                      valid_q, valid_d;
    logic                      multi_q, multi_d;
    logic                      start_prev_q, start_prev_d;
    logic                      start_pulse_q, start_pulse_d;

    assign raw_all_s = {start_raw, btn_raw};

    for (genvar i = 0; i < NUM_COLOR_KEYS + 1; i++) begin : g_deb
        button_conditioner_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_all_s[i]),
            .level (level_s[i])
        );
    end

    assign keys_s      = level_s[NUM_COLOR_KEYS-1:0];
    assign start_lvl_s = level_s[NUM_COLOR_KEYS];
    assign one_hot_s   = (keys_s != 4'b0000) && ((keys_s & (keys_s - 4'd1)) == 4'b0000);
    assign multi_s     = (keys_s != 4'b0000) && !one_hot_s;

    // blocked_q: a multi-key chord was seen in IDLE; nothing is accepted until all keys are up.
    always_comb begin
        state_d       = state_q;
        blocked_d     = blocked_q;
        button_d      = button_q;
        valid_d       = 1'b0;
        multi_d       = multi_s;
        start_prev_d  = start_lvl_s;
        start_pulse_d = start_lvl_s & ~start_prev_q;
        case (state_q)
            BTN_IDLE: begin
                if (keys_s == 4'b0000) begin
                    blocked_d = 1'b0;
                end else if (multi_s) begin
                    blocked_d = 1'b1;
                end else if (!blocked_q) begin
                    state_d  = BTN_HELD;
                    valid_d  = 1'b1;
                    button_d = COLOR_CODEFY_W'(encode_color(keys_s));
                end else begin
                    blocked_d = 1'b1;
                end
            end
            BTN_HELD: begin
                if (keys_s == 4'b0000) begin
                    state_d = BTN_IDLE;
                end else begin
                    state_d = BTN_HELD;
                end
            end
            default: begin
                state_d   = BTN_IDLE;
                blocked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BTN_IDLE;
            blocked_q     <= 1'b0;
            button_q      <= {COLOR_CODEFY_W{1'b0}};
            valid_q       <= 1'b0;
            multi_q       <= 1'b0;
            start_prev_q  <= 1'b0;
            start_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            blocked_q     <= blocked_d;
            button_q      <= button_d;
            valid_q       <= valid_d;
            multi_q       <= multi_d;
            start_prev_q  <= start_prev_d;
            start_pulse_q <= start_pulse_d;
        end
    end

    assign player_button = button_q;
    assign player_valid  = valid_q;
    assign start_pulse   = start_pulse_q;
    assign multi_press   = multi_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4; also runs with +define+BTN_ACTIVE_LOW_EN.
module tb_button_conditioner;

    localparam int DC  = 4;
    localparam int LAT = DC + 3;

`ifdef BTN_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic       start_raw;
    logic [1:0] player_button;
    logic       player_valid;
    logic       start_pulse;
    logic       multi_press;

    int cyc = 0;
    int vectors = 0;
    int fails = 0;
    bit done = 1'b0;

    typedef struct {
        int         cyc;
        logic [1:0] code;
    } col_exp_t;

    typedef struct {
        int    cyc;
        int    kind;   // 0 player_valid, 1 player_button, 2 start_pulse, 3 multi_press
        int    val;
        string name;
    } lvl_exp_t;

    col_exp_t col_q[$];
    int       start_q[$];
    lvl_exp_t lvl_q[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .COLOR_CODEFY_W  (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .start_raw     (start_raw),
        .player_button (player_button),
        .player_valid  (player_valid),
        .start_pulse   (start_pulse),
        .multi_press   (multi_press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic [3:0] b, input logic s);
        btn_raw   = b ^ {4{INV}};
        start_raw = s ^ INV;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_color(input logic [1:0] code);
        col_exp_t e;
        e.cyc  = cyc + LAT;
        e.code = code;
        col_q.push_back(e);
    endtask

    task automatic exp_level(input int kind, input int val, input string name);
        lvl_exp_t e;
        e.cyc  = cyc + 1;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        lvl_q.push_back(e);
    endtask

    // Monitor: every comparison of the run happens here.
    initial begin
        col_exp_t ce;
        lvl_exp_t le;
        int       sc;
        int       act;
        forever begin
            @(negedge clk);
            if (player_valid) begin
                vectors++;
                if (col_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_player_valid: cycle %0d code %0d, none expected", cyc, player_button);
                end else begin
                    ce = col_q.pop_front();
                    if (ce.cyc != cyc || ce.code != player_button) begin
                        fails++;
                        $display("FAIL player_strobe: got cycle %0d code %0d, expected cycle %0d code %0d",
                                 cyc, player_button, ce.cyc, ce.code);
                    end
                end
            end
            if (start_pulse) begin
                vectors++;
                if (start_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_start_pulse: cycle %0d, none expected", cyc);
                end else begin
                    sc = start_q.pop_front();
                    if (sc != cyc) begin
                        fails++;
                        $display("FAIL start_pulse: got cycle %0d, expected cycle %0d", cyc, sc);
                    end
                end
            end
            while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
                le = lvl_q.pop_front();
                case (le.kind)
                    0:       act = int'(player_valid);
                    1:       act = int'(player_button);
                    2:       act = int'(start_pulse);
                    default: act = int'(multi_press);
                endcase
                vectors++;
                if (act != le.val) begin
                    fails++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d)", le.name, act, le.val, cyc);
                end
            end
            if (done) begin
                vectors++;
                if (col_q.size() != 0 || start_q.size() != 0) begin
                    fails++;
                    $display("FAIL missing_strobes: %0d color and %0d start strobes never seen, expected 0",
                             col_q.size(), start_q.size());
                end
                $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
                $finish;
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 1'b0;
        drive(4'b0100, 1'b0);
        idle(2);
        exp_level(0, 0, "rst_player_valid");
        exp_level(1, 0, "rst_player_button");
        exp_level(2, 0, "rst_start_pulse");
        exp_level(3, 0, "rst_multi_press");
        idle(2);
        rst_n = 1'b1;
        exp_color(2'd2);
        idle(15);
        drive(4'b0000, 1'b0);
        idle(12);

        // bounce on green, ending stable high
        for (int i = 0; i < 5; i++) begin
            drive(((i % 2) == 0) ? 4'b0010 : 4'b0000, 1'b0);
            if (i == 4) exp_color(2'd1);
            idle(2);
        end
        idle(13);
        exp_level(1, 1, "bounce_button_held");
        idle(1);
        drive(4'b0000, 1'b0);
        idle(12);

        // red held, yellow added later: only the red strobe
        drive(4'b0001, 1'b0);
        exp_color(2'd0);
        idle(20);
        drive(4'b1001, 1'b0);
        idle(10);
        exp_level(3, 1, "held_multi_press");
        exp_level(1, 0, "held_button_red");
        idle(1);
        drive(4'b0000, 1'b0);
        idle(12);
        exp_level(3, 0, "held_release_multi");
        idle(1);
        drive(4'b1000, 1'b0);
        exp_color(2'd3);
        idle(12);
        drive(4'b0000, 1'b0);
        idle(12);

        // simultaneous red+yellow: no strobe, even after yellow alone is released
        drive(4'b1001, 1'b0);
        idle(10);
        exp_level(3, 1, "simul_multi_press");
        exp_level(1, 3, "simul_button_kept");
        idle(2);
        drive(4'b0001, 1'b0);
        idle(12);
        exp_level(3, 0, "simul_one_left_multi");
        idle(1);
        drive(4'b0000, 1'b0);
        idle(12);
        exp_level(3, 0, "simul_release_multi");
        idle(1);

        // start held 50 cycles, then a 3-cycle glitch
        drive(4'b0000, 1'b1);
        start_q.push_back(cyc + LAT);
        idle(50);
        drive(4'b0000, 1'b0);
        idle(12);
        drive(4'b0000, 1'b1);
        idle(3);
        drive(4'b0000, 1'b0);
        idle(12);

        // start and blue together
        drive(4'b0100, 1'b1);
        start_q.push_back(cyc + LAT);
        exp_color(2'd2);
        idle(12);
        drive(4'b0000, 1'b0);
        idle(12);

        // reset mid-press, green held through it
        drive(4'b0010, 1'b0);
        idle(5);
        rst_n = 1'b0;
        idle(2);
        exp_level(1, 0, "midrst_player_button");
        exp_level(3, 0, "midrst_multi_press");
        idle(2);
        rst_n = 1'b1;
        exp_color(2'd1);
        idle(12);
        drive(4'b0000, 1'b0);
        idle(12);

        done = 1'b1;
        idle(20);
        $display("FAIL monitor_stall: summary not reached");
        $fatal(1, "monitor stalled");
    end

endmodule
